aes_key_sched_ctrl: RTL
=======================

Name: aes_key_sched_ctrl

Overview:
- Sequencer for AES-128 key expansion.
- On key_start from the state manager, it reads the 4 cipher-key words from the key matrix and expands them one word per cycle (words 4..43) using an external shared S-box.
- It writes each completed 128-bit round key (rounds 0..10) to the round-key store, then pulses key_expand_done back to the state manager.

Parameters:
- NR, 10, number of rounds; round keys 0..NR are written.
- WORD_W, 32, expansion word width in bits.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- key_start  input  1  expansion request from state manager; sampled only in IDLE.
- key_word_idx  output  2  key-matrix column being read during LOAD.
- key_word_in  input  32  key-matrix column selected by key_word_idx (combinational source).
- sbox_in  output  32  RotWord(w[i-1]) presented to the shared 4-byte S-box.
- sbox_out  input  32  bytewise SubBytes(sbox_in), combinational return.
- rk_wr_en  output  1  round-key store write strobe, one cycle per round key.
- rk_wr_addr  output  4  round index 0..NR.
- rk_wr_data  output  128  round key, {w[4r],w[4r+1],w[4r+2],w[4r+3]}; w[4r] in [127:96].
- busy  output  1  high in LOAD and EXPAND.
- key_expand_done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high.
- Reset values: state=IDLE, key_word_idx=0, rk_wr_en=0, rk_wr_addr=0, rk_wr_data=0, busy=0, key_expand_done=0, word counter=0, rcon=8'h01, 4-word window=0.
- Byte order: byte 0 = [31:24]. RotWord(x) = {x[23:0], x[31:24]}.
- States:
  - IDLE: key_start=1 -> LOAD, counter=0.
  - LOAD: key_word_idx=counter. Each edge shifts key_word_in into window[3] (window[0] is the oldest). Counter runs 0..3. At count 3 -> EXPAND, counter=4.
  - EXPAND: each edge computes w[i] (i = counter, 4..43) and shifts it into the window:
    - if i%4==0: w[i] = window[0] ^ sbox_out ^ {rcon,24'h0}, then rcon <= xtime(rcon) (0x80 -> 0x1B).
    - otherwise: w[i] = window[0] ^ window[3].
    - At i=43 -> IDLE.
  - sbox_in always equals RotWord(window[3]); the value is only consumed when i%4==0.
- Round-key writes (registered): on the edge where the window becomes {w[4r]..w[4r+3]}, set rk_wr_en<=1, rk_wr_addr<=r, rk_wr_data<=new window. Otherwise rk_wr_en<=0.
- Timing: key_start sampled at edge E0.
  - Key words are captured at E1..E4; round 0 is written in the cycle after E4.
  - Round r is written in the cycle after E4+4r; round 10 after E44.
  - key_expand_done is high in the cycle after E44, coincident with the round-10 write. busy drops in that same cycle.
- Total latency: 44 edges from key_start to done. 11 writes per run, addresses strictly ascending 0..10.
- rcon reloads 8'h01 on entry to LOAD, so back-to-back runs are independent.
- Boundary conditions:
  - key_start while busy: ignored; the run continues unaffected.
  - key_start held high: a new run starts in the cycle after done; no lost or duplicated writes.
  - key_start in the same cycle as the done pulse: FSM is already in IDLE, so it is accepted.
  - reset mid-run: all outputs return to reset values on that edge, no further writes occur, and key_expand_done is not pulsed.
  - key_word_in changing outside LOAD: no effect.

Decomposition:
- Shared package aes_pkg:
  - state enum (IDLE, LOAD, EXPAND)
  - NK=4, NB=4, NR=10
  - function xtime(byte)
  - function rot_word(word)
- One natural sub-module: aes_rcon_gen (register plus xtime with load/advance).
- The word datapath stays inline. The S-box is external and shared.

Test Plan:
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, bench behavioural S-box -> round 1 = a0fafe17 88542cb1 23a33939 2a6c7605; round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6; done exactly 44 edges after start; 11 writes with addresses 0..10.
- All-zero key -> round 1 = 62636363 62636363 62636363 62636363; round 10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
- key_start pulsed again 10 and 30 cycles into a run -> identical write sequence and a single done pulse.
- Reset asserted 20 cycles after start -> all outputs 0 next cycle and no writes or done afterwards. A fresh start then yields the correct FIPS-197 keys (rcon restarted at 01).
- key_start held high across two runs with different keys -> second run begins in the done cycle; both key sets correct; rk_wr_en never high in two consecutive cycles.
- key_word_in changed every cycle during EXPAND -> round keys unchanged from the first scenario.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and byte/word helpers.
package aes_pkg;

  localparam int NK     = 4;
  localparam int NB     = 4;
  localparam int NR     = 10;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2
  } state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: reloads 0x01 on load, steps by xtime on advance.
// One-cycle update, no backpressure; reset value 0x01.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       adv_i,
  output logic [7:0] rcon_o
);

  logic [7:0] rcon_q, rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (load_i) begin
      rcon_d = 8'h01;
    end else if (adv_i) begin
      rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rcon_q <= 8'h01;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion sequencer: 4 load cycles then one expanded word per cycle.
// Done pulses 44 edges after key_start; requests while busy are ignored.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = aes_pkg::NR,
  parameter int WORD_W = aes_pkg::WORD_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  key_start,
  output logic [1:0]            key_word_idx,
  input  logic [WORD_W-1:0]     key_word_in,
  output logic [WORD_W-1:0]     sbox_in,
  input  logic [WORD_W-1:0]     sbox_out,
  output logic                  rk_wr_en,
  output logic [3:0]            rk_wr_addr,
  output logic [4*WORD_W-1:0]   rk_wr_data,
  output logic                  busy,
  output logic                  key_expand_done
);

  localparam int LAST_WORD = 4 * (NR + 1) - 1;

  state_e                    state_q, state_d;
  logic [5:0]                cnt_q, cnt_d;
  // Index 0 is the oldest word and lands in the MSBs of the packed window.
  logic [0:3][WORD_W-1:0]    win_q, win_d;
  logic [WORD_W-1:0]         new_word;
  logic                      wr_d;
  logic                      done_d;
  logic                      rk_wr_en_q;
  logic [3:0]                rk_wr_addr_q;
  logic [4*WORD_W-1:0]       rk_wr_data_q;
  logic                      done_q;
  logic [7:0]                rcon;
  logic                      rcon_load;
  logic                      rcon_adv;

  assign rcon_load = (state_q == IDLE) && key_start;
  assign rcon_adv  = (state_q == EXPAND) && (cnt_q[1:0] == 2'd0);

  aes_rcon_gen u_rcon (
    .clk_i  (clock),
    .rst_i  (reset),
    .load_i (rcon_load),
    .adv_i  (rcon_adv),
    .rcon_o (rcon)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    new_word = '0;
    wr_d     = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_start) begin
          state_d = LOAD;
          cnt_d   = 6'd0;
        end
      end
      LOAD: begin
        win_d = {win_q[1:3], key_word_in};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd3) begin
          state_d = EXPAND;
          wr_d    = 1'b1;
        end
      end
      EXPAND: begin
        if (cnt_q[1:0] == 2'd0) begin
          new_word = win_q[0] ^ sbox_out ^ {rcon, {(WORD_W-8){1'b0}}};
        end else begin
          new_word = win_q[0] ^ win_q[3];
        end
        win_d = {win_q[1:3], new_word};
        cnt_d = cnt_q + 6'd1;
        wr_d  = (cnt_q[1:0] == 2'd3);
        if (cnt_q == 6'(LAST_WORD)) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 6'd0;
      win_q        <= '0;
      rk_wr_en_q   <= 1'b0;
      rk_wr_addr_q <= 4'd0;
      rk_wr_data_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      rk_wr_en_q <= wr_d;
      done_q     <= done_d;
      if (wr_d) begin
        rk_wr_addr_q <= cnt_q[5:2];
        rk_wr_data_q <= win_d;
      end
    end
  end

  assign key_word_idx    = (state_q == LOAD) ? cnt_q[1:0] : 2'd0;
  assign sbox_in         = rot_word(win_q[3]);
  assign rk_wr_en        = rk_wr_en_q;
  assign rk_wr_addr      = rk_wr_addr_q;
  assign rk_wr_data      = rk_wr_data_q;
  assign busy            = (state_q != IDLE);
  assign key_expand_done = done_q;

endmodule
